// File: rtl/chip8_timer_unit_if.sv
// CPU/video-facing signal bundle for the CHIP-8 delay/sound timer unit.
// The master side (cpu + video) drives loads and vsync; the slave side is the timer unit.
interface chip8_timer_unit_if;
  logic       vsync;
  logic       dt_we;
  logic       st_we;
  logic [7:0] wdata;
  logic [7:0] dt_value;
  logic [7:0] st_value;
  logic       tick;
  logic       beep;
  logic       spkr;

  modport master (
    output vsync, dt_we, st_we, wdata,
    input  dt_value, st_value, tick, beep, spkr
  );

  modport slave (
    input  vsync, dt_we, st_we, wdata,
    output dt_value, st_value, tick, beep, spkr
  );
endinterface

// File: rtl/chip8_timer_unit.sv
// CHIP-8 delay and sound timers, decremented once per vsync rising edge,
// plus the speaker square-wave generator gated by a non-zero sound timer.
module chip8_timer_unit #(
  parameter int TONE_HALF = 2048,
  parameter int ST_MIN    = 2
) (
  input  logic               clk,
  input  logic               reset,
  chip8_timer_unit_if.slave  bus
);

  typedef enum logic {IDLE, RUN} tone_state_t;

  localparam logic [15:0] TONE_LAST = 16'(TONE_HALF - 1);
  localparam logic [8:0]  ST_MIN_W  = 9'(ST_MIN);

  logic        vsync_q;
  logic [7:0]  dt_next;
  logic [7:0]  st_next;
  logic [7:0]  st_load;
  logic [15:0] tone_cnt;
  tone_state_t tone_state;

  // Writes take priority over the tick so a load never loses a count.
  always_comb begin
    st_load = ({1'b0, bus.wdata} < ST_MIN_W) ? 8'd0 : bus.wdata;

    dt_next = bus.dt_value;
    if (bus.dt_we)
      dt_next = bus.wdata;
    else if (bus.tick && (bus.dt_value != 8'd0))
      dt_next = bus.dt_value - 8'd1;

    st_next = bus.st_value;
    if (bus.st_we)
      st_next = st_load;
    else if (bus.tick && (bus.st_value != 8'd0))
      st_next = bus.st_value - 8'd1;
  end

  // vsync_q resets high so a vsync already high at release is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q      <= 1'b1;
      bus.tick     <= 1'b0;
      bus.dt_value <= 8'd0;
      bus.st_value <= 8'd0;
      bus.beep     <= 1'b0;
    end else begin
      vsync_q      <= bus.vsync;
      bus.tick     <= bus.vsync & ~vsync_q;
      bus.dt_value <= dt_next;
      bus.st_value <= st_next;
      bus.beep     <= (st_next != 8'd0);
    end
  end

  // Tone phase always starts high on a fresh beep; reloads mid-beep keep the phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tone_state <= IDLE;
      tone_cnt   <= 16'd0;
      bus.spkr   <= 1'b0;
    end else begin
      case (tone_state)
        IDLE: begin
          tone_cnt <= 16'd0;
          if (bus.beep) begin
            tone_state <= RUN;
            bus.spkr   <= 1'b1;
          end else begin
            bus.spkr   <= 1'b0;
          end
        end
        RUN: begin
          if (!bus.beep) begin
            tone_state <= IDLE;
            tone_cnt   <= 16'd0;
            bus.spkr   <= 1'b0;
          end else if (tone_cnt == TONE_LAST) begin
            tone_cnt <= 16'd0;
            bus.spkr <= ~bus.spkr;
          end else begin
            tone_cnt <= tone_cnt + 16'd1;
          end
        end
        default: begin
          tone_state <= IDLE;
          tone_cnt   <= 16'd0;
          bus.spkr   <= 1'b0;
        end
      endcase
    end
  end

endmodule
